fetch_unit: RTL

Instruction fetch stage that sits directly upstream of the IF/ID pipeline register and feeds it with {pc, instruction} pairs. It owns the program counter and issues in-order requests to instruction memory with a bounded number outstanding. Returned words are buffered in a small prefetch FIFO and presented to decode through a valid/ready handshake. Branch redirects from EX discard all in-flight and buffered wrong-path fetches.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 60 ++++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants, entry type and helpers for the fetch stage
package fetch_pkg;
  localparam int PC_W = 64;
  localparam int INSTR_W = 32;
  localparam logic [PC_W-1:0] RESET_PC = '0;
  localparam int INSTR_BYTES = 4;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [7:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {25'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - registered prefetch FIFO of fetch entries with flush
// Head is read straight from storage; a push is visible one cycle later.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  input  logic             clear,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t     mem_q [DEPTH];
  fetch_entry_t     mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC owner, credit-limited imem issue and redirect flush for IF/ID
// Optional FETCH_PERF_CNT_EN adds saturating perf_fetched / perf_dropped counters.
module fetch_unit #(
  parameter int              PC_W       = fetch_pkg::PC_W,
  parameter int              INSTR_W    = fetch_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC   = fetch_pkg::RESET_PC,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               if_valid,
  output logic [PC_W-1:0]    if_pc,
  output logic [INSTR_W-1:0] if_instr,
  input  logic               if_ready,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_dropped
`endif
);
  import fetch_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PC_W-1:0] STEP = PC_W'(INSTR_BYTES);

  logic [PC_W-1:0]  pc_q, pc_d, resp_pc_q, resp_pc_d, target;
  logic [CNT_W-1:0] out_q, out_d, drop_q, drop_d, fifo_count;
  logic [CNT_W:0]   credit_used;
  logic             push, pop, dropping;
  fetch_entry_t     push_entry, head;

  assign if_valid = (fifo_count != '0);
  assign pop      = if_valid & if_ready & ~redirect_valid;
  assign target   = {redirect_pc[PC_W-1:2], 2'b00};

  // A slot freed by this cycle's pop can be reused: its response lands at least a cycle later.
  assign credit_used = {1'b0, out_q} + {1'b0, fifo_count} - (CNT_W+1)'(pop);
  assign imem_req    = rst & ~redirect_valid & (credit_used < (CNT_W+1)'(FIFO_DEPTH));
  assign imem_addr   = pc_q;

  assign dropping   = imem_rvalid & (drop_q != '0);
  assign push       = imem_rvalid & ~redirect_valid & (drop_q == '0);
  assign push_entry = '{pc: resp_pc_q, instr: imem_rdata};

  always_comb begin
    pc_d      = pc_q;
    resp_pc_d = resp_pc_q;
    out_d     = out_q;
    drop_d    = drop_q;
    if (redirect_valid) begin
      pc_d      = target;
      resp_pc_d = target;
      out_d     = out_q - CNT_W'(imem_rvalid);
      drop_d    = out_d;
    end else begin
      if (imem_req) pc_d = pc_q + STEP;
      if (push) resp_pc_d = resp_pc_q + STEP;
      if (dropping) drop_d = drop_q - CNT_W'(1);
      out_d = out_q + CNT_W'(imem_req) - CNT_W'(imem_rvalid);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q      <= RESET_PC;
      resp_pc_q <= RESET_PC;
      out_q     <= '0;
      drop_q    <= '0;
    end else begin
      pc_q      <= pc_d;
      resp_pc_q <= resp_pc_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .clear     (redirect_valid),
    .head      (head),
    .count     (fifo_count)
  );

  assign if_pc    = if_valid ? head.pc : '0;
  assign if_instr = if_valid ? head.instr : '0;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetched_q, fetched_d, dropped_q, dropped_d;
  logic [7:0]  drop_inc;

  // A redirect discards the buffered entries plus any response landing that cycle.
  always_comb begin
    drop_inc = redirect_valid ? (8'(fifo_count) + 8'(imem_rvalid)) : 8'(dropping);
    fetched_d = sat_add32(fetched_q, 8'(pop));
    dropped_d = sat_add32(dropped_q, drop_inc);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetched_q <= '0;
      dropped_q <= '0;
    end else begin
      fetched_q <= fetched_d;
      dropped_q <= dropped_d;
    end
  end

  assign perf_fetched = fetched_q;
  assign perf_dropped = dropped_q;
`endif
endmodule
